// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through word-addressed memory and queues
// {pc, instr} pairs into a 2-entry buffer for decode; stops at a zero word, restarts on redirect.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StDone} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [1:0]  count_q;
  logic [31:0] pc0_q, instr0_q, pc1_q, instr1_q;
  logic [31:0] fetch_count_q;

  logic redirect, pop, push, zero_word;

  always_comb begin
    redirect  = redirect_valid && (state_q != StBoot);
    pop       = (count_q != 2'd0) && out_ready;
    zero_word = (imem_instr == 32'h0000_0000);
    push      = (state_q == StRun) && !redirect_valid && !zero_word &&
                ((count_q != 2'd2) || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      count_q       <= 2'd0;
      pc0_q         <= 32'h0;
      instr0_q      <= 32'h0;
      pc1_q         <= 32'h0;
      instr1_q      <= 32'h0;
      fetch_count_q <= 32'h0;
    end else if (redirect) begin
      // Any coincident pop is already accepted by decode; the flush drops the rest.
      state_q <= StRun;
      pc_q    <= {redirect_pc[31:2], 2'b00};
      count_q <= 2'd0;
    end else begin
      unique case (state_q)
        StBoot:  state_q <= StRun;
        StRun:   if (zero_word) state_q <= StDone;
        default: state_q <= state_q;
      endcase

      // Entry 0 is always the head; entry 1 is only meaningful at count 2.
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_q    <= pc_q;
            instr0_q <= imem_instr;
          end else begin
            pc1_q    <= pc_q;
            instr1_q <= imem_instr;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          pc0_q    <= pc1_q;
          instr0_q <= instr1_q;
          count_q  <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            pc0_q    <= pc_q;
            instr0_q <= imem_instr;
          end else begin
            pc0_q    <= pc1_q;
            instr0_q <= instr1_q;
            pc1_q    <= pc_q;
            instr1_q <= imem_instr;
          end
        end
        default: count_q <= count_q;
      endcase

      if (push) begin
        pc_q          <= pc_q + 32'd4;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_pc      = pc0_q;
  assign out_instr   = instr0_q;
  assign halted      = (state_q == StDone);
  assign fetch_count = fetch_count_q;

endmodule
